// File: rtl/ray_bounce_sequencer.sv
// Serializes one ray through intersect/reflect bounces over a shared reflector and emits its light.
// Optional saturating ray/bounce/miss counters are built when RAY_SEQ_STATS_EN is defined.
// Vector/color buses are three packed fp24 fields {x|r, y|g, z|b}; material is a 32-bit opaque record.
module ray_bounce_sequencer #(
  parameter int MAX_BOUNCES = 4,
  parameter int TAG_W       = 20
) (
  input  logic             clk,
  input  logic             rst,
  // upstream camera rays
  input  logic             ray_in_valid,
  output logic             ray_in_ready,
  input  logic [71:0]      ray_in_origin,
  input  logic [71:0]      ray_in_dir,
  input  logic [TAG_W-1:0] ray_in_tag,
  // scene intersector
  output logic             trace_req_valid,
  input  logic             trace_req_ready,
  output logic [71:0]      trace_origin,
  output logic [71:0]      trace_dir,
  input  logic             trace_resp_valid,
  input  logic             trace_hit,
  input  logic [71:0]      trace_hit_pos,
  input  logic [71:0]      trace_hit_normal,
  input  logic [31:0]      trace_hit_mat,
  // shared reflector
  output logic [71:0]      rflx_ray_dir,
  output logic [71:0]      rflx_ray_color,
  output logic [71:0]      rflx_income_light,
  output logic [71:0]      rflx_hit_pos,
  output logic [71:0]      rflx_hit_normal,
  output logic [31:0]      rflx_hit_mat,
  output logic             rflx_hit_valid,
  output logic [47:0]      rflx_lfsr_seed,
  input  logic [71:0]      rflx_new_dir,
  input  logic [71:0]      rflx_new_origin,
  input  logic [71:0]      rflx_new_color,
  input  logic [71:0]      rflx_new_income_light,
  input  logic             rflx_done,
  // pixel output
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [71:0]      pix_light,
  output logic [TAG_W-1:0] pix_tag,
  output logic [3:0]       pix_bounces,
  // statistics
  output logic [31:0]      stat_rays,
  output logic [31:0]      stat_bounces,
  output logic [31:0]      stat_misses
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_TRACE_REQ  = 3'd1;
  localparam logic [2:0] ST_TRACE_WAIT = 3'd2;
  localparam logic [2:0] ST_REFLECT    = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE  = 3'd4;
  localparam logic [2:0] ST_EMIT       = 3'd5;

  localparam logic [71:0] COLOR_ONE    = {3{24'h3F0000}};
  localparam logic [47:0] SEED_INIT    = 48'h0000_0000_0001;
  localparam logic [47:0] SEED_STEP    = 48'h9E37_79B9_7F4A;
  localparam logic [3:0]  BOUNCE_LIMIT = 4'(MAX_BOUNCES);

  logic [2:0]       state_r;
  logic [2:0]       next_state_s;

  logic [71:0]      origin_r;
  logic [71:0]      dir_r;
  logic [71:0]      color_r;
  logic [71:0]      light_r;
  logic [TAG_W-1:0] tag_r;
  logic [3:0]       bounce_cnt_r;
  logic [3:0]       bounce_next_s;
  logic [71:0]      hit_pos_r;
  logic [71:0]      hit_normal_r;
  logic [31:0]      hit_mat_r;
  logic [47:0]      seed_r;

  logic             ray_in_ready_r;
  logic             trace_req_valid_r;
  logic             rflx_hit_valid_r;
  logic             pix_valid_r;

  logic             accept_s;
  logic             req_fire_s;
  logic             resp_s;
  logic             done_s;
  logic             emit_fire_s;

  // Handshake events, each qualified by the state in which it is meaningful
  always_comb begin
    accept_s      = (state_r == ST_IDLE)       && ray_in_valid;
    req_fire_s    = (state_r == ST_TRACE_REQ)  && trace_req_ready;
    resp_s        = (state_r == ST_TRACE_WAIT) && trace_resp_valid;
    done_s        = (state_r == ST_WAIT_DONE)  && rflx_done;
    emit_fire_s   = (state_r == ST_EMIT)       && pix_ready;
    bounce_next_s = bounce_cnt_r + 4'd1;
  end

  // Next-state decode of the bounce FSM
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_state_s = ST_TRACE_REQ;
        else          next_state_s = ST_IDLE;
      end
      ST_TRACE_REQ: begin
        if (req_fire_s) next_state_s = ST_TRACE_WAIT;
        else            next_state_s = ST_TRACE_REQ;
      end
      ST_TRACE_WAIT: begin
        if (resp_s && trace_hit)  next_state_s = ST_REFLECT;
        else if (resp_s)          next_state_s = ST_EMIT;
        else                      next_state_s = ST_TRACE_WAIT;
      end
      ST_REFLECT: begin
        next_state_s = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (done_s && (bounce_next_s == BOUNCE_LIMIT)) next_state_s = ST_EMIT;
        else if (done_s)                              next_state_s = ST_TRACE_REQ;
        else                                          next_state_s = ST_WAIT_DONE;
      end
      ST_EMIT: begin
        if (emit_fire_s) next_state_s = ST_IDLE;
        else             next_state_s = ST_EMIT;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register plus flopped handshake outputs that mirror the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r           <= ST_IDLE;
      ray_in_ready_r    <= 1'b1;
      trace_req_valid_r <= 1'b0;
      rflx_hit_valid_r  <= 1'b0;
      pix_valid_r       <= 1'b0;
    end else begin
      state_r           <= next_state_s;
      ray_in_ready_r    <= (next_state_s == ST_IDLE);
      trace_req_valid_r <= (next_state_s == ST_TRACE_REQ);
      rflx_hit_valid_r  <= (next_state_s == ST_REFLECT);
      pix_valid_r       <= (next_state_s == ST_EMIT);
    end
  end

  // Per-ray working registers: loaded on accept, replaced by each reflector result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      origin_r     <= 72'd0;
      dir_r        <= 72'd0;
      color_r      <= 72'd0;
      light_r      <= 72'd0;
      tag_r        <= {TAG_W{1'b0}};
      bounce_cnt_r <= 4'd0;
    end else if (accept_s) begin
      origin_r     <= ray_in_origin;
      dir_r        <= ray_in_dir;
      color_r      <= COLOR_ONE;
      light_r      <= 72'd0;
      tag_r        <= ray_in_tag;
      bounce_cnt_r <= 4'd0;
    end else if (done_s) begin
      origin_r     <= rflx_new_origin;
      dir_r        <= rflx_new_dir;
      color_r      <= rflx_new_color;
      light_r      <= rflx_new_income_light;
      bounce_cnt_r <= bounce_next_s;
    end
  end

  // Hit record held stable for the reflector from REFLECT through WAIT_DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_pos_r    <= 72'd0;
      hit_normal_r <= 72'd0;
      hit_mat_r    <= 32'd0;
    end else if (resp_s && trace_hit) begin
      hit_pos_r    <= trace_hit_pos;
      hit_normal_r <= trace_hit_normal;
      hit_mat_r    <= trace_hit_mat;
    end
  end

  // Reflector seed: golden-ratio stride per honored bounce, kept across rays
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_r <= SEED_INIT;
    end else if (done_s) begin
      seed_r <= seed_r + SEED_STEP;
    end
  end

  assign ray_in_ready      = ray_in_ready_r;
  assign trace_req_valid   = trace_req_valid_r;
  assign trace_origin      = origin_r;
  assign trace_dir         = dir_r;
  assign rflx_ray_dir      = dir_r;
  assign rflx_ray_color    = color_r;
  assign rflx_income_light = light_r;
  assign rflx_hit_pos      = hit_pos_r;
  assign rflx_hit_normal   = hit_normal_r;
  assign rflx_hit_mat      = hit_mat_r;
  assign rflx_hit_valid    = rflx_hit_valid_r;
  assign rflx_lfsr_seed    = seed_r;
  assign pix_valid         = pix_valid_r;
  assign pix_light         = light_r;
  assign pix_tag           = tag_r;
  assign pix_bounces       = bounce_cnt_r;

`ifdef RAY_SEQ_STATS_EN
  logic [31:0] stat_rays_r;
  logic [31:0] stat_bounces_r;
  logic [31:0] stat_misses_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

  // Saturating path statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rays_r    <= 32'd0;
      stat_bounces_r <= 32'd0;
      stat_misses_r  <= 32'd0;
    end else begin
      if (accept_s)             stat_rays_r    <= sat_inc(stat_rays_r);
      if (done_s)               stat_bounces_r <= sat_inc(stat_bounces_r);
      if (resp_s && !trace_hit) stat_misses_r  <= sat_inc(stat_misses_r);
    end
  end

  assign stat_rays    = stat_rays_r;
  assign stat_bounces = stat_bounces_r;
  assign stat_misses  = stat_misses_r;
`else
  assign stat_rays    = 32'd0;
  assign stat_bounces = 32'd0;
  assign stat_misses  = 32'd0;
`endif

endmodule

// File: tb/tb_ray_bounce_sequencer.sv
// Directed bench for ray_bounce_sequencer: miss path, full bounce budget, partial path, back-pressure, reset mid-path.
module tb_ray_bounce_sequencer;

  localparam int TAG_W = 20;
  localparam logic [71:0] ONE3  = {3{24'h3F0000}};
  localparam logic [47:0] STEP  = 48'h9E37_79B9_7F4A;

  logic             clk = 1'b0;
  logic             rst;
  logic             ray_in_valid, ray_in_ready;
  logic [71:0]      ray_in_origin, ray_in_dir;
  logic [TAG_W-1:0] ray_in_tag;
  logic             trace_req_valid, trace_req_ready;
  logic [71:0]      trace_origin, trace_dir;
  logic             trace_resp_valid, trace_hit;
  logic [71:0]      trace_hit_pos, trace_hit_normal;
  logic [31:0]      trace_hit_mat;
  logic [71:0]      rflx_ray_dir, rflx_ray_color, rflx_income_light, rflx_hit_pos, rflx_hit_normal;
  logic [31:0]      rflx_hit_mat;
  logic             rflx_hit_valid;
  logic [47:0]      rflx_lfsr_seed;
  logic [71:0]      rflx_new_dir, rflx_new_origin, rflx_new_color, rflx_new_income_light;
  logic             rflx_done;
  logic             pix_valid, pix_ready;
  logic [71:0]      pix_light;
  logic [TAG_W-1:0] pix_tag;
  logic [3:0]       pix_bounces;
  logic [31:0]      stat_rays, stat_bounces, stat_misses;

  int checks = 0;
  int failures = 0;
  int hit_pulses = 0;
  logic [47:0] exp_seed;

  ray_bounce_sequencer #(.MAX_BOUNCES(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .ray_in_valid(ray_in_valid), .ray_in_ready(ray_in_ready),
    .ray_in_origin(ray_in_origin), .ray_in_dir(ray_in_dir), .ray_in_tag(ray_in_tag),
    .trace_req_valid(trace_req_valid), .trace_req_ready(trace_req_ready),
    .trace_origin(trace_origin), .trace_dir(trace_dir),
    .trace_resp_valid(trace_resp_valid), .trace_hit(trace_hit),
    .trace_hit_pos(trace_hit_pos), .trace_hit_normal(trace_hit_normal), .trace_hit_mat(trace_hit_mat),
    .rflx_ray_dir(rflx_ray_dir), .rflx_ray_color(rflx_ray_color), .rflx_income_light(rflx_income_light),
    .rflx_hit_pos(rflx_hit_pos), .rflx_hit_normal(rflx_hit_normal), .rflx_hit_mat(rflx_hit_mat),
    .rflx_hit_valid(rflx_hit_valid), .rflx_lfsr_seed(rflx_lfsr_seed),
    .rflx_new_dir(rflx_new_dir), .rflx_new_origin(rflx_new_origin),
    .rflx_new_color(rflx_new_color), .rflx_new_income_light(rflx_new_income_light),
    .rflx_done(rflx_done),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_light(pix_light), .pix_tag(pix_tag), .pix_bounces(pix_bounces),
    .stat_rays(stat_rays), .stat_bounces(stat_bounces), .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rflx_hit_valid === 1'b1) hit_pulses <= hit_pulses + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_ray(input logic [TAG_W-1:0] tag, input logic [71:0] org, input logic [71:0] dir);
    check("accept_ready", ray_in_ready, 1'b1);
    ray_in_valid = 1'b1; ray_in_tag = tag; ray_in_origin = org; ray_in_dir = dir;
    tick();
    ray_in_valid = 1'b0;
    check("req_after_accept", trace_req_valid, 1'b1);
    check("busy_not_ready", ray_in_ready, 1'b0);
  endtask

  task automatic grant_req();
    int n = 0;
    while (trace_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", trace_req_valid, 1'b1);
    trace_req_ready = 1'b1;
    tick();
    trace_req_ready = 1'b0;
    check("req_dropped", trace_req_valid, 1'b0);
  endtask

  task automatic respond(input logic hit, input logic [71:0] pos, input logic [71:0] nrm, input logic [31:0] mat);
    trace_resp_valid = 1'b1; trace_hit = hit;
    trace_hit_pos = pos; trace_hit_normal = nrm; trace_hit_mat = mat;
    tick();
    trace_resp_valid = 1'b0; trace_hit = 1'b0;
  endtask

  task automatic reflect(input logic [71:0] ndir, input logic [71:0] norg, input logic [71:0] ncol,
                         input logic [71:0] nlight, input int delay);
    check("hit_valid_on", rflx_hit_valid, 1'b1);
    tick();
    check("hit_valid_pulse", rflx_hit_valid, 1'b0);
    repeat (delay) tick();
    rflx_done = 1'b1;
    rflx_new_dir = ndir; rflx_new_origin = norg; rflx_new_color = ncol; rflx_new_income_light = nlight;
    tick();
    rflx_done = 1'b0;
    exp_seed = exp_seed + STEP;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [71:0] light_tab [4];
    logic [71:0] org_tab [4];
    logic [71:0] dir_tab [4];
    logic [71:0] col_tab [4];
    logic [71:0] hpos, hnrm;
    logic [31:0] hmat;
    int pulses0;

    light_tab = '{{3{24'h3D0000}}, {3{24'h3E0000}}, {3{24'h3E8000}}, {3{24'h3F0000}}};
    org_tab   = '{72'h410000_000000_3F0000, 72'h410000_3F0000_3F0000, 72'h418000_3F0000_400000, 72'h420000_400000_400000};
    dir_tab   = '{72'h000000_3F0000_000000, 72'hBF0000_000000_000000, 72'h000000_000000_3F0000, 72'h3F0000_BF0000_000000};
    col_tab   = '{{3{24'h3E8000}}, {3{24'h3E0000}}, {3{24'h3D0000}}, {3{24'h3C0000}}};
    hpos = 72'h400000_3F8000_C08000;
    hnrm = 72'h000000_3F0000_000000;
    hmat = 32'hA5A5_0C03;

    rst = 1'b1;
    ray_in_valid = 1'b0; ray_in_origin = 72'd0; ray_in_dir = 72'd0; ray_in_tag = '0;
    trace_req_ready = 1'b0; trace_resp_valid = 1'b0; trace_hit = 1'b0;
    trace_hit_pos = 72'd0; trace_hit_normal = 72'd0; trace_hit_mat = 32'd0;
    rflx_new_dir = 72'd0; rflx_new_origin = 72'd0; rflx_new_color = 72'd0; rflx_new_income_light = 72'd0;
    rflx_done = 1'b0; pix_ready = 1'b0;
    exp_seed = 48'h1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    check("rst_ready", ray_in_ready, 1'b1);
    check("rst_req_valid", trace_req_valid, 1'b0);
    check("rst_hit_valid", rflx_hit_valid, 1'b0);
    check("rst_pix_valid", pix_valid, 1'b0);
    check("rst_seed", rflx_lfsr_seed, 48'h1);
    check("rst_pix_light", pix_light, 72'd0);
    check("rst_stat_rays", stat_rays, 32'd0);

    // spurious reflector done right after reset
    rflx_done = 1'b1; rflx_new_origin = 72'hDEAD;
    tick();
    rflx_done = 1'b0;
    check("spur_done_ready", ray_in_ready, 1'b1);
    check("spur_done_seed", rflx_lfsr_seed, 48'h1);
    check("spur_done_origin", trace_origin, 72'd0);
    check("spur_done_req", trace_req_valid, 1'b0);

    // ray tag 5: stray response during TRACE_REQ, then a miss
    send_ray(20'd5, 72'h3F0000_400000_410000, 72'hBF0000_000000_3E8000);
    check("t5_origin", trace_origin, 72'h3F0000_400000_410000);
    check("t5_dir", trace_dir, 72'hBF0000_000000_3E8000);
    respond(1'b0, 72'd0, 72'd0, 32'd0);
    check("stray_resp_req_held", trace_req_valid, 1'b1);
    check("stray_resp_no_pix", pix_valid, 1'b0);
    grant_req();
    respond(1'b0, 72'd0, 72'd0, 32'd0);
    check("miss_pix_valid", pix_valid, 1'b1);
    check("miss_light", pix_light, 72'd0);
    check("miss_bounces", pix_bounces, 4'd0);
    check("miss_tag", pix_tag, 20'd5);
    pix_ready = 1'b1;
    tick();
    pix_ready = 1'b0;
    check("miss_pix_done", pix_valid, 1'b0);
    check("miss_idle_ready", ray_in_ready, 1'b1);

    // ray tag 9: every trace hits, reflector adds 0.25 per bounce
    pulses0 = hit_pulses;
    send_ray(20'd9, 72'h3F0000_3F0000_3F0000, 72'h000000_000000_BF0000);
    for (int k = 0; k < 4; k++) begin
      grant_req();
      respond(1'b1, hpos, hnrm, hmat);
      check("full_hit_pos", rflx_hit_pos, hpos);
      check("full_hit_mat", rflx_hit_mat, hmat);
      check("full_seed", rflx_lfsr_seed, exp_seed);
      if (k == 0) begin
        check("full_color0", rflx_ray_color, ONE3);
        check("full_light0", rflx_income_light, 72'd0);
      end else begin
        check("full_color", rflx_ray_color, col_tab[k-1]);
        check("full_light", rflx_income_light, light_tab[k-1]);
        check("full_dir", rflx_ray_dir, dir_tab[k-1]);
      end
      reflect(dir_tab[k], org_tab[k], col_tab[k], light_tab[k], 3);
      if (k < 3) begin
        check("full_next_req", trace_req_valid, 1'b1);
        check("full_next_origin", trace_origin, org_tab[k]);
      end
    end
    check("full_pix_valid", pix_valid, 1'b1);
    check("full_no_req", trace_req_valid, 1'b0);
    check("full_bounces", pix_bounces, 4'd4);
    check("full_light_one", pix_light, ONE3);
    check("full_tag", pix_tag, 20'd9);
    check("full_pulses", hit_pulses - pulses0, 96'd4);
    check("full_seed_end", rflx_lfsr_seed, 48'h78DD_E6E5_FD29);

    // back-pressure: pix_ready low for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_pix_valid", pix_valid, 1'b1);
      check("hold_light", pix_light, ONE3);
      check("hold_not_ready", ray_in_ready, 1'b0);
    end
    pix_ready = 1'b1;
    tick();
    pix_ready = 1'b0;
    check("hold_release", pix_valid, 1'b0);
    check("hold_idle", ray_in_ready, 1'b1);

    // ray tag 3: hit, hit, miss
    send_ray(20'd3, 72'h3E0000_3E0000_3E0000, 72'h3F0000_000000_000000);
    grant_req();
    respond(1'b1, hpos, hnrm, hmat);
    reflect(dir_tab[1], org_tab[2], col_tab[0], light_tab[0], 1);
    check("part_origin2", trace_origin, org_tab[2]);
    grant_req();
    respond(1'b1, hpos, hnrm, hmat);
    check("part_color2", rflx_ray_color, col_tab[0]);
    reflect(dir_tab[2], org_tab[3], col_tab[1], light_tab[1], 0);
    check("part_origin3", trace_origin, org_tab[3]);
    grant_req();
    respond(1'b0, 72'd0, 72'd0, 32'd0);
    check("part_pix_valid", pix_valid, 1'b1);
    check("part_bounces", pix_bounces, 4'd2);
    check("part_light", pix_light, light_tab[1]);
    check("part_tag", pix_tag, 20'd3);
    check("part_seed", rflx_lfsr_seed, exp_seed);
    pix_ready = 1'b1;
    tick();
    pix_ready = 1'b0;
`ifdef RAY_SEQ_STATS_EN
    check("stat_rays", stat_rays, 32'd3);
    check("stat_bounces", stat_bounces, 32'd6);
    check("stat_misses", stat_misses, 32'd2);
`else
    check("stat_rays_off", stat_rays, 32'd0);
    check("stat_bounces_off", stat_bounces, 32'd0);
    check("stat_misses_off", stat_misses, 32'd0);
`endif

    // reset pulse while waiting on the reflector
    send_ray(20'd7, 72'h3F0000_000000_000000, 72'h000000_3F0000_000000);
    grant_req();
    respond(1'b1, hpos, hnrm, hmat);
    tick();
    check("mid_wait_state", rflx_hit_valid, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", ray_in_ready, 1'b1);
    check("mid_rst_pix", pix_valid, 1'b0);
    check("mid_rst_seed", rflx_lfsr_seed, 48'h1);
    check("mid_rst_hitpos", rflx_hit_pos, 72'd0);
    check("mid_rst_tag", pix_tag, 20'd0);
    tick();
    rst = 1'b0;
    rflx_done = 1'b1; rflx_new_origin = org_tab[0]; rflx_new_income_light = ONE3;
    trace_resp_valid = 1'b1; trace_hit = 1'b0;
    tick();
    rflx_done = 1'b0; trace_resp_valid = 1'b0;
    tick();
    check("late_done_ready", ray_in_ready, 1'b1);
    check("late_done_seed", rflx_lfsr_seed, 48'h1);
    check("late_done_origin", trace_origin, 72'd0);
    check("late_done_light", pix_light, 72'd0);
    check("late_done_req", trace_req_valid, 1'b0);
    check("late_done_pix", pix_valid, 1'b0);
    check("late_stat_misses", stat_misses, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
